frame_ram: RTL and testbench

Single-clock, parametrised frame-buffer RAM for the fractal renderer. It holds one signed value per pixel (iteration count or colour index), with one write port and one read port. It adds three things over the existing buffer RAM: a selectable read latency with a valid strobe, address range checking, and a hardware clear engine that fills the whole buffer with CLEAR_VALUE between frames. It sits between the iteration pipeline (writer) and the VGA scan-out (reader).

---
 rtl/fractal_pkg.sv | 16 +
 rtl/frame_ram_clear_ctrl.sv | 88 ++++++++
 rtl/frame_ram.sv | 149 ++++++++++++++
 tb/tb_frame_ram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal renderer: frame geometry and the
// frame_ram clear-engine state encoding.
package fractal_pkg;

  localparam int FB_WIDTH     = 640;
  localparam int FB_HEIGHT    = 480;
  localparam int FB_DEPTH     = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_SIZE = 19;

  // Clear engine states: IDLE accepts external writes, CLEAR owns the write port.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } frame_ram_state_e;

endpackage

// File: rtl/frame_ram_clear_ctrl.sv
// Clear engine for frame_ram: walks every address once, driving a write
// request for CLEAR_VALUE per cycle, and reports busy/done to the outside.
module frame_ram_clear_ctrl
  import fractal_pkg::*;
#(
  parameter int DEPTH     = FB_DEPTH,
  parameter int ADDR_SIZE = FB_ADDR_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_start,
  output logic                 clear_we,
  output logic [ADDR_SIZE-1:0] clear_addr,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 idle
);

  // Last word to clear; the walk terminates here so the counter never wraps.
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  frame_ram_state_e       state_r;
  frame_ram_state_e       state_next_s;
  logic [ADDR_SIZE-1:0]   count_r;
  logic [ADDR_SIZE-1:0]   count_next_s;
  logic                   done_r;
  logic                   done_next_s;
  logic                   busy_r;
  logic                   clear_we_s;

  // State register, address counter and the registered busy/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      done_r  <= done_next_s;
      busy_r  <= (state_next_s == CLEAR);
    end
  end

  // Next-state logic: start on request, write one word per cycle, stop on the last word.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    done_next_s  = 1'b0;
    clear_we_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_start) begin
          state_next_s = CLEAR;
          count_next_s = '0;
        end else begin
          state_next_s = IDLE;
          count_next_s = '0;
        end
      end
      CLEAR: begin
        // A repeated clear_start is ignored here: the walk is never restarted.
        clear_we_s = 1'b1;
        if (count_r == LAST_ADDR) begin
          state_next_s = IDLE;
          count_next_s = '0;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = CLEAR;
          count_next_s = count_r + ADDR_SIZE'(1'b1);
        end
      end
      default: begin
        state_next_s = IDLE;
        count_next_s = '0;
      end
    endcase
  end

  assign clear_we   = clear_we_s;
  assign clear_addr = count_r;
  assign clear_busy = busy_r;
  assign clear_done = done_r;
  // External writes are only accepted while the engine is parked.
  assign idle       = (state_r == IDLE);

endmodule

// File: rtl/frame_ram.sv
// Frame-buffer RAM: one signed word per pixel, one write port shared with a
// hardware clear engine, one read port with 1- or 2-cycle latency and a
// valid strobe, and range checking on both ports.
module frame_ram
  import fractal_pkg::*;
#(
  parameter int                          DEPTH       = FB_DEPTH,
  parameter int                          ADDR_SIZE   = FB_ADDR_SIZE,
  parameter int                          DATA_SIZE   = 4,
  parameter int                          RD_LATENCY  = 2,
  parameter logic signed [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_SIZE-1:0]        wr_addr,
  input  logic signed [DATA_SIZE-1:0] data_in,
  output logic                        wr_ready,
  input  logic                        rd_en,
  input  logic [ADDR_SIZE-1:0]        rd_addr,
  output logic signed [DATA_SIZE-1:0] data_out,
  output logic                        rd_valid,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done
);

  // Index width actually needed by the array; in-range addresses fit in it.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  logic signed [DATA_SIZE-1:0] mem_r [DEPTH];

  logic                        clear_we_s;
  logic [ADDR_SIZE-1:0]        clear_addr_s;
  logic                        idle_s;

  logic                        wr_in_range_s;
  logic                        rd_in_range_s;
  logic                        mem_we_s;
  logic [ADDR_SIZE-1:0]        mem_addr_s;
  logic signed [DATA_SIZE-1:0] mem_data_s;
  logic signed [DATA_SIZE-1:0] rd_word_s;

  logic signed [DATA_SIZE-1:0] data_out_r;
  logic                        rd_valid_r;

  frame_ram_clear_ctrl #(
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_clear_ctrl (
    .clock       (clock),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_we    (clear_we_s),
    .clear_addr  (clear_addr_s),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .idle        (idle_s)
  );

  assign wr_ready      = idle_s;
  assign wr_in_range_s = (wr_addr <= LAST_ADDR);
  assign rd_in_range_s = (rd_addr <= LAST_ADDR);

  // Write-port arbitration: reset blocks all writes, clear beats external writes.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    mem_data_s = '0;
    if (reset) begin
      // An aborted clear leaves words 0..counter-1 cleared and nothing more.
      mem_we_s = 1'b0;
    end else if (clear_we_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = clear_addr_s;
      mem_data_s = CLEAR_VALUE;
    end else if (wr_en && idle_s && wr_in_range_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = wr_addr;
      mem_data_s = data_in;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array; contents are deliberately not touched by reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s[IDX_W-1:0]] <= mem_data_s;
    end
  end

  // The array is sampled in the request cycle, so a same-cycle write to the
  // same word is not seen (read-first). Out-of-range reads return zero.
  assign rd_word_s = rd_in_range_s ? mem_r[rd_addr[IDX_W-1:0]] : '0;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      // Single-stage read: result and strobe at the end of the request cycle.
      always_ff @(posedge clock) begin
        if (reset) begin
          data_out_r <= '0;
          rd_valid_r <= 1'b0;
        end else begin
          rd_valid_r <= rd_en;
          if (rd_en) begin
            data_out_r <= rd_word_s;
          end else begin
            data_out_r <= data_out_r;
          end
        end
      end
    end else begin : g_lat2
      logic                        stage_valid_r;
      logic signed [DATA_SIZE-1:0] stage_data_r;

      // First stage: capture the request and the read-first word.
      always_ff @(posedge clock) begin
        if (reset) begin
          stage_valid_r <= 1'b0;
          stage_data_r  <= '0;
        end else begin
          stage_valid_r <= rd_en;
          stage_data_r  <= rd_word_s;
        end
      end

      // Second stage: present the result one cycle later, holding otherwise.
      always_ff @(posedge clock) begin
        if (reset) begin
          data_out_r <= '0;
          rd_valid_r <= 1'b0;
        end else begin
          rd_valid_r <= stage_valid_r;
          if (stage_valid_r) begin
            data_out_r <= stage_data_r;
          end else begin
            data_out_r <= data_out_r;
          end
        end
      end
    end
  endgenerate

  assign data_out = data_out_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_frame_ram.sv
// Self-checking bench for frame_ram: two instances (read latency 1 and 2)
// share one stimulus stream; a word-array reference model predicts every output.
module tb_frame_ram;

  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int CLR   = -1;

  logic                 clock;
  logic                 reset;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] data_in;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic                 clear_start;

  logic signed [DW-1:0] data_out1, data_out2;
  logic                 rd_valid1, rd_valid2;
  logic                 wr_ready1, wr_ready2;
  logic                 busy1, busy2;
  logic                 done1, done2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  int mem_m [DEPTH];
  bit clearing = 1'b0;
  int pos = 0;
  bit exp_done = 1'b0;
  bit exp1_v = 1'b0, exp2_v = 1'b0, prev_v = 1'b0;
  int last1 = 0, last2 = 0, prev_d = 0;

  frame_ram #(
    .DEPTH(DEPTH), .ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LATENCY(1), .CLEAR_VALUE(4'sb1111)
  ) dut1 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out1),
    .rd_valid(rd_valid1), .clear_start(clear_start), .clear_busy(busy1), .clear_done(done1)
  );

  frame_ram #(
    .DEPTH(DEPTH), .ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LATENCY(2), .CLEAR_VALUE(4'sb1111)
  ) dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .wr_ready(wr_ready2), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out2),
    .rd_valid(rd_valid2), .clear_start(clear_start), .clear_busy(busy2), .clear_done(done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from the inputs sampled at the edge,
  // then compare every DUT output shortly after the edge.
  task automatic tick();
    bit cv;
    int rv;
    @(posedge clock);
    cv = 1'b0;
    rv = 0;
    if (!reset && rd_en) begin
      cv = 1'b1;
      rv = (rd_addr < DEPTH) ? mem_m[rd_addr] : 0;
    end
    if (reset) begin
      exp1_v = 1'b0; exp2_v = 1'b0; prev_v = 1'b0;
      last1 = 0; last2 = 0; prev_d = 0;
    end else begin
      exp1_v = cv;
      if (cv) last1 = rv;
      exp2_v = prev_v;
      if (prev_v) last2 = prev_d;
      prev_v = cv;
      prev_d = rv;
    end
    exp_done = 1'b0;
    if (reset) begin
      clearing = 1'b0;
      pos = 0;
    end else if (clearing) begin
      mem_m[pos] = CLR;
      pos++;
      if (pos == DEPTH) begin
        clearing = 1'b0;
        pos = 0;
        exp_done = 1'b1;
      end
    end else begin
      if (wr_en && wr_addr < DEPTH) mem_m[wr_addr] = int'(data_in);
      if (clear_start) begin
        clearing = 1'b1;
        pos = 0;
      end
    end
    #1;
    check("lat1_valid", rd_valid1, exp1_v);
    check("lat1_data", data_out1, last1);
    check("lat2_valid", rd_valid2, exp2_v);
    check("lat2_data", data_out2, last2);
    check("busy1", busy1, clearing);
    check("busy2", busy2, clearing);
    check("done1", done1, exp_done);
    check("done2", done2, exp_done);
    check("ready1", wr_ready1, !clearing);
    check("ready2", wr_ready2, !clearing);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      rd_addr = AW'(a);
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int busy_n;
    int done_n;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; data_in = '0;
    rd_en = 1'b0; rd_addr = '0; clear_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // clear with a write in the start cycle, held throughout the clear
    clear_start = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; data_in = 4'sd6;
    tick();
    busy_n = busy2 ? 1 : 0;
    done_n = 0;
    for (int i = 1; i <= 20; i++) begin
      clear_start = (i == 6) ? 1'b1 : 1'b0;
      if (i == 18) wr_en = 1'b0;
      tick();
      if (busy2) busy_n++;
      if (done2) done_n++;
    end
    check("busy_len", busy_n, 16);
    check("done_cnt", done_n, 1);
    read_all();

    // write 5 @ 3, then read it
    wr_en = 1'b1; wr_addr = 5'd3; data_in = 4'sd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd3;
    tick();
    check("l1_rd5", data_out1, 5);
    rd_en = 1'b0;
    tick();
    check("l2_rd5", data_out2, 5);
    check("l2_rd5_v", rd_valid2, 1);
    tick();

    // writes 1..4 to 0..3, then back-to-back reads
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); data_in = DW'(a + 1);
      tick();
    end
    wr_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();

    // same-cycle write and read of word 2 is read-first
    wr_en = 1'b1; wr_addr = 5'd2; data_in = 4'sd7; rd_en = 1'b1; rd_addr = 5'd2;
    tick();
    check("rfw_old", data_out1, 3);
    wr_en = 1'b0;
    tick();
    check("rfw_old2", data_out2, 3);
    check("rfw_new", data_out1, 7);
    rd_en = 1'b0;
    tick();
    tick();

    // out-of-range write and read
    wr_en = 1'b1; wr_addr = 5'd20; data_in = 4'sd6;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd16;
    tick();
    check("oor_d1", data_out1, 0);
    check("oor_v1", rd_valid1, 1);
    rd_en = 1'b0;
    tick();
    check("oor_d2", data_out2, 0);
    read_all();

    // randomized traffic, including clears during reads and occasional resets
    for (int c = 0; c < 300; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      wr_en       = 1'($urandom);
      wr_addr     = AW'($urandom_range(0, 19));
      data_in     = DW'($urandom);
      rd_en       = 1'($urandom);
      rd_addr     = AW'($urandom_range(0, 19));
      clear_start = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    read_all();

    // distinct non-(-1) contents, then a clear aborted by reset at cycle 8
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); data_in = DW'(a % 7);
      tick();
    end
    wr_en = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy2, 0);
    check("abort_ready", wr_ready2, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    read_all();
    rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    check("abort_w7", data_out1, -1);
    rd_addr = 5'd8;
    tick();
    check("abort_w8", data_out1, 1);
    rd_en = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
